load_store_unit: RTL

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

---
 rtl/load_store_unit.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - load/store unit bridging core memory instructions to a req/ack bus
//
// Purpose: accepts one load or store from the core and checks its alignment.
// A legal access is issued as a single word-aligned bus request with byte
// strobes. The unit waits for bus_ack or for the timeout, then returns
// extended load data and a fault flag with a one-cycle done pulse.
//
// Ports:
//   clk, reset                   clock, synchronous active-high reset
//   req_valid, mem_read,         core request and load/store flags
//   mem_write, funct3
//   addr, wdata                  byte address and store data
//   stall                        core holds PC/instruction while busy
//   done, err, rdata             completion pulse, fault flag, load result
//   bus_req, bus_we, bus_addr,   memory-side request (registered)
//   bus_wstrb, bus_wdata
//   bus_ack, bus_rdata           memory-side response
module load_store_unit #(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        stall,
  output logic        done,
  output logic        err,
  output logic [31:0] rdata,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_wstrb,
  output logic [31:0] bus_wdata,
  input  logic        bus_ack,
  input  logic [31:0] bus_rdata
);

  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  state_t        state, state_nx;
  logic          accept;
  logic          is_store;
  logic          legal;
  logic [3:0]    strb_nx;
  logic [31:0]   wdata_nx;
  logic [31:0]   lane;
  logic [31:0]   load_val;
  logic [2:0]    f3_q;
  logic [1:0]    off_q;
  logic [CW-1:0] cnt;
  logic          expire;

  // Request decode: store wins when both flags are set.
  always_comb begin
    accept   = (state == IDLE) && req_valid && (mem_read || mem_write);
    is_store = mem_write;
    legal    = 1'b0;
    strb_nx  = 4'b0000;
    wdata_nx = wdata;
    case (funct3)
      3'b000: begin
        legal    = 1'b1;
        strb_nx  = 4'b0001 << addr[1:0];
        wdata_nx = {4{wdata[7:0]}};
      end
      3'b001: begin
        legal    = !addr[0];
        strb_nx  = addr[1] ? 4'b1100 : 4'b0011;
        wdata_nx = {2{wdata[15:0]}};
      end
      3'b010: begin
        legal    = (addr[1:0] == 2'b00);
        strb_nx  = 4'b1111;
      end
      3'b100:  legal = !is_store;
      3'b101:  legal = !is_store && !addr[0];
      default: legal = 1'b0;
    endcase
    if (!is_store) begin
      strb_nx = 4'b0000;
    end
  end

  // Load extraction uses the byte offset captured at accept time, since
  // bus_addr is word aligned.
  always_comb begin
    lane     = bus_rdata >> {off_q, 3'b000};
    load_val = bus_rdata;
    case (f3_q)
      3'b000:  load_val = {{24{lane[7]}}, lane[7:0]};
      3'b001:  load_val = {{16{lane[15]}}, lane[15:0]};
      3'b100:  load_val = {24'h0, lane[7:0]};
      3'b101:  load_val = {16'h0, lane[15:0]};
      default: load_val = bus_rdata;
    endcase
  end

  assign expire = (cnt == CW'(TIMEOUT - 1));

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (accept) state_nx = legal ? ACCESS : DONE;
      ACCESS:  if (bus_ack || expire) state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      bus_req   <= 1'b0;
      bus_we    <= 1'b0;
      bus_addr  <= 32'h0;
      bus_wstrb <= 4'h0;
      bus_wdata <= 32'h0;
      err       <= 1'b0;
      rdata     <= 32'h0;
      cnt       <= '0;
      f3_q      <= 3'b000;
      off_q     <= 2'b00;
    end else begin
      state <= state_nx;
      case (state)
        IDLE: begin
          if (accept) begin
            cnt <= '0;
            if (legal) begin
              bus_req   <= 1'b1;
              bus_we    <= is_store;
              bus_addr  <= {addr[31:2], 2'b00};
              bus_wstrb <= strb_nx;
              bus_wdata <= wdata_nx;
              f3_q      <= funct3;
              off_q     <= addr[1:0];
            end else begin
              err   <= 1'b1;
              rdata <= 32'h0;
            end
          end
        end
        ACCESS: begin
          // bus_ack is checked first so it wins over a same-cycle timeout.
          if (bus_ack) begin
            bus_req <= 1'b0;
            err     <= 1'b0;
            rdata   <= bus_we ? 32'h0 : load_val;
            cnt     <= '0;
          end else if (expire) begin
            bus_req <= 1'b0;
            err     <= 1'b1;
            rdata   <= 32'h0;
            cnt     <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign stall = accept || (state == ACCESS);
  assign done  = (state == DONE);

endmodule
